// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 data mux between four requesters.
// A grant lasts for one burst. Each beat in the burst is a registered output with a valid flag.
module mux_rr_arbiter #(
  parameter int W        = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic [W-1:0] i2,
  input  logic [W-1:0] i3,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic [W-1:0] y,
  output logic         y_valid
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [1:0]     ptr;
  logic [1:0]     ptr_nxt;
  logic [CW-1:0]  hold_cnt;
  logic [CW-1:0]  hold_nxt;
  logic [CW-1:0]  hold_inc;
  logic [3:0]     gnt_nxt;
  logic [1:0]     sel_nxt;
  logic [W-1:0]   y_nxt;
  logic           y_valid_nxt;
  logic [W-1:0]   owner_data;
  logic [3:0]     req_rot;
  logic [1:0]     offset;
  logic [1:0]     winner;
  logic           release_now;

  // Shared data mux steered by the registered select
  always_comb begin
    owner_data = i0;
    case (sel)
      2'd0:    owner_data = i0;
      2'd1:    owner_data = i1;
      2'd2:    owner_data = i2;
      2'd3:    owner_data = i3;
      default: owner_data = i0;
    endcase
  end

  // Rotate requests so bit 0 is the pointer position, then take the first set bit
  always_comb begin
    req_rot = 4'({req, req} >> ptr);
    offset  = 2'd0;
    casez (req_rot)
      4'b???1: offset = 2'd0;
      4'b??10: offset = 2'd1;
      4'b?100: offset = 2'd2;
      4'b1000: offset = 2'd3;
      default: offset = 2'd0;
    endcase
    winner = ptr + offset;
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    sel_nxt     = sel;
    y_nxt       = y;
    y_valid_nxt = 1'b0;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    hold_inc    = hold_cnt + CW'(1);
    release_now = 1'b0;
    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          gnt_nxt   = 4'b0001 << winner;
          sel_nxt   = winner;
          hold_nxt  = {CW{1'b0}};
          state_nxt = GRANT;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (req[sel]) begin
          y_nxt       = owner_data;
          y_valid_nxt = 1'b1;
          // The beat that reaches the limit is still sent on the releasing edge
          if (hold_inc == CW'(MAX_HOLD)) begin
            release_now = 1'b1;
          end else begin
            hold_nxt = hold_inc;
          end
        end else begin
          release_now = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
        hold_nxt  = {CW{1'b0}};
      end
    endcase
    if (release_now) begin
      gnt_nxt   = 4'b0000;
      state_nxt = IDLE;
      ptr_nxt   = sel + 2'd1;
      hold_nxt  = {CW{1'b0}};
    end else begin
      hold_nxt  = hold_nxt;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'b00;
      y        <= {W{1'b0}};
      y_valid  <= 1'b0;
      ptr      <= 2'b00;
      hold_cnt <= {CW{1'b0}};
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      y        <= y_nxt;
      y_valid  <= y_valid_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a reference model queues the expected outputs and beats.
// A monitor on the clock checks the DUT against those queues.
module tb_mux_rr_arbiter;
  localparam int W        = 3;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [W-1:0] i0, i1, i2, i3;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [W-1:0] y;
  logic         y_valid;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .gnt(gnt), .sel(sel), .y(y), .y_valid(y_valid)
  );

  typedef struct packed {
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [W-1:0] y;
    logic         y_valid;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] beat_q[$];
  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;
  bit done  = 1'b0;

  // Reference model: owner is -1 when nobody holds the mux
  int           m_owner = -1;
  int           m_ptr   = 0;
  int           m_cnt   = 0;
  int           m_sel   = 0;
  logic [W-1:0] m_y     = '0;
  bit           m_yv    = 1'b0;

  task automatic step(input logic r, input logic [3:0] rq);
    logic [W-1:0] d[4];
    exp_t e;
    int o;
    @(negedge clk);
    for (int k = 0; k < 4; k++) d[k] = W'($urandom);
    rst = r; req = rq;
    i0 = d[0]; i1 = d[1]; i2 = d[2]; i3 = d[3];
    m_yv = 1'b0;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0; m_y = '0;
    end else if (m_owner < 0) begin
      for (int s = 0; s < 4; s++) begin
        if (m_owner < 0 && rq[(m_ptr + s) % 4]) begin
          m_owner = (m_ptr + s) % 4;
          m_sel   = m_owner;
          m_cnt   = 0;
        end
      end
    end else begin
      o = m_owner;
      if (rq[o]) begin
        m_y  = d[o];
        m_yv = 1'b1;
        m_cnt++;
      end
      if (!rq[o] || m_cnt == MAX_HOLD) begin
        m_owner = -1;
        m_ptr   = (o + 1) % 4;
        m_cnt   = 0;
      end
    end
    e.gnt     = (m_owner < 0) ? 4'b0000 : 4'(4'b0001 << m_owner);
    e.sel     = 2'(m_sel);
    e.y       = m_y;
    e.y_valid = m_yv;
    exp_q.push_back(e);
    if (m_yv) beat_q.push_back(m_y);
    armed = 1'b1;
  endtask

  // Monitor: one state record every cycle, one beat record per valid output
  initial begin
    exp_t e;
    logic [W-1:0] b;
    forever begin
      @(posedge clk);
      #1;
      if (!done) begin
        if (exp_q.size() == 0) begin
          if (armed) begin
            total++; bad++;
            $display("FAIL exp_underflow: no expected record at time %0t", $time);
          end
        end else begin
          e = exp_q.pop_front();
          total++;
          if ({gnt, sel, y, y_valid} !== e) begin
            bad++;
            $display("FAIL state t=%0t: got gnt=%b sel=%b y=%b v=%b want gnt=%b sel=%b y=%b v=%b",
                     $time, gnt, sel, y, y_valid, e.gnt, e.sel, e.y, e.y_valid);
          end
        end
        if (y_valid === 1'b1) begin
          total++;
          if (beat_q.size() == 0) begin
            bad++;
            $display("FAIL beat_extra t=%0t: got y=%b want no beat", $time, y);
          end else begin
            b = beat_q.pop_front();
            if (y !== b) begin
              bad++;
              $display("FAIL beat t=%0t: got y=%b want %b", $time, y, b);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] rq;
    logic       r;
    rst = 1'b1; req = 4'b0000;
    i0 = '0; i1 = '0; i2 = '0; i3 = '0;
    // reset with everyone requesting, then the full rotation
    step(1'b1, 4'b1111); step(1'b1, 4'b1111);
    repeat (45) step(1'b0, 4'b1111);
    // short burst from requester 1
    step(1'b1, 4'b0000);
    repeat (3) step(1'b0, 4'b0010);
    repeat (3) step(1'b0, 4'b0000);
    // owner 2 drops while requester 3 rises
    step(1'b1, 4'b0000);
    repeat (2) step(1'b0, 4'b0100);
    repeat (5) step(1'b0, 4'b1000);
    step(1'b0, 4'b0000);
    // ptr=1 after owner 0 releases, then 1001 grants 3 before 0
    step(1'b1, 4'b0000);
    repeat (3) step(1'b0, 4'b0001);
    repeat (12) step(1'b0, 4'b1001);
    // reset mid-burst
    step(1'b1, 4'b0000);
    repeat (4) step(1'b0, 4'b0100);
    step(1'b1, 4'b0100);
    repeat (4) step(1'b0, 4'b0101);
    // random bursty traffic with occasional resets
    rq = 4'b0000;
    repeat (3000) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) rq[k] = ~rq[k];
      end
      r = ($urandom_range(0, 63) == 0);
      step(r, rq);
    end
    @(posedge clk);
    #2;
    done = 1'b1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL exp_left: got %0d records pending want 0", exp_q.size());
    end
    total++;
    if (beat_q.size() != 0) begin
      bad++;
      $display("FAIL beats_left: got %0d beats pending want 0", beat_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
